bitstream_pattern_detector: RTL and testbench

Runtime-programmable serial pattern detector, successor to the fixed 10010 detector. It takes one bit per qualified cycle and compares a sliding window against a loaded pattern of 1..PAT_W bits. It raises a one-cycle `flag` on each match and keeps a saturating match count. Overlapping or non-overlapping detection is selectable, and the block sits directly on a serial receive path behind the bit-sync logic.

---
 rtl/bitstream_det_pkg.sv | 14 +
 rtl/bitstream_pattern_detector_window.sv | 58 +++++
 rtl/bitstream_pattern_detector.sv | 116 +++++++++++
 tb/tb_bitstream_pattern_detector.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/bitstream_det_pkg.sv
// Shared definitions for the bitstream pattern detector.
//   - FSM state encoding (IDLE / FILL / HUNT)
//   - len_w(): width of a field that can hold 0..pat_w
package bitstream_det_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HUNT = 2'd2;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/bitstream_pattern_detector_window.sv
// Sliding window, fill counter and masked comparator.
//   clk, rst_n  : clock, async active-low reset
//   clr_i       : clear window and fill count (config load)
//   shift_i     : accept din_i this cycle
//   restart_i   : on a hit, drop fill count to 0 (non-overlap mode)
//   din_i       : serial bit, shifted in at the LSB
//   pattern_i   : pattern, low len_i bits significant
//   len_i       : pattern length 1..PAT_W
//   hit_o       : combinational match on the post-shift window
//   full_o      : fill count after this shift equals len_i
module bitstream_window
  import bitstream_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             restart_i,
  input  logic             din_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             hit_o,
  output logic             full_o
);

  logic [PAT_W-1:0] win_q, win_d;
  logic [LEN_W-1:0] fill_q, fill_d, fill_inc;
  logic [PAT_W-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len_i));
  end

  assign win_d    = {win_q[PAT_W-2:0], din_i};
  // Saturate at len so a long HUNT never wraps the counter.
  assign fill_inc = (fill_q >= len_i) ? len_i : fill_q + LEN_W'(1);
  assign full_o   = shift_i && (fill_inc == len_i);
  assign hit_o    = full_o && ((win_d & mask) == (pattern_i & mask));
  assign fill_d   = (hit_o && restart_i) ? '0 : fill_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      fill_q <= '0;
    end else if (clr_i) begin
      win_q  <= '0;
      fill_q <= '0;
    end else if (shift_i) begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/bitstream_pattern_detector.sv
// Runtime-programmable serial pattern detector.
//   clk, rst_n          : clock, async active-low reset
//   cfg_load            : strobe latching cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern/len     : pattern (MSB of len bits received first) and length
//   cfg_overlap         : 1 = overlapping matches, 0 = restart after match
//   din_vld, din        : qualified serial input bit
//   flag                : one-cycle registered match pulse
//   match_cnt           : saturating matches since last load
//   cfg_err             : one-cycle pulse on a rejected load
//   armed               : a valid pattern is loaded
module bitstream_pattern_detector
  import bitstream_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             din_vld,
  input  logic             din,
  output logic             flag,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err,
  output logic             armed
);

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             armed_q, armed_d;
  logic             len_ok, shift, hit, full;

  assign len_ok = (cfg_len != '0) && (int'(cfg_len) <= PAT_W);
  // A load in the same cycle wins; that bit is dropped.
  assign shift  = din_vld && !cfg_load && (state_q != ST_IDLE);

  bitstream_window #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cfg_load),
    .shift_i  (shift),
    .restart_i(!ovl_q),
    .din_i    (din),
    .pattern_i(pat_q),
    .len_i    (len_q),
    .hit_o    (hit),
    .full_o   (full)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    flag_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    armed_d = armed_q;
    if (cfg_load) begin
      cnt_d = '0;
      if (len_ok) begin
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        state_d = ST_FILL;
        armed_d = 1'b1;
      end else begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
        armed_d = 1'b0;
      end
    end else if (shift) begin
      flag_d = hit;
      if (hit && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (hit && !ovl_q)      state_d = ST_FILL;
      else if (full)          state_d = ST_HUNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      armed_q <= armed_d;
    end
  end

  assign flag      = flag_q;
  assign match_cnt = cnt_q;
  assign cfg_err   = err_q;
  assign armed     = armed_q;

endmodule

// File: tb/tb_bitstream_pattern_detector.sv
// Directed bench: two instances share inputs; u_dut (CNT_W=8) and
// u_sat (CNT_W=2) for the saturation case.
module tb_bitstream_pattern_detector;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             din_vld = 1'b0;
  logic             din = 1'b0;
  logic             flag, cfg_err, armed;
  logic [7:0]       match_cnt;
  logic             flag2, cfg_err2, armed2;
  logic [1:0]       match_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bitstream_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_vld(din_vld), .din(din),
    .flag(flag), .match_cnt(match_cnt), .cfg_err(cfg_err), .armed(armed));

  bitstream_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_vld(din_vld), .din(din),
    .flag(flag2), .match_cnt(match_cnt2), .cfg_err(cfg_err2), .armed(armed2));

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] pat, input int len, input logic ovl,
                      input logic vld, input logic b);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = LEN_W'(len);
    cfg_overlap = ovl; din_vld = vld; din = b;
    @(posedge clk); #1;
    cfg_load = 1'b0; din_vld = 1'b0;
  endtask

  // Drive one valid bit and check flag right after the sampling edge.
  task automatic bit_in(input logic b, input logic exp_flag, input string tag);
    din_vld = 1'b1; din = b;
    @(posedge clk); #1;
    din_vld = 1'b0;
    chk(tag, flag, exp_flag);
  endtask

  task automatic gap;
    din_vld = 1'b0; din = 1'b1;
    @(posedge clk); #1;
    chk("gap_flag", flag, 0);
  endtask

  logic [7:0] s10010 = 8'b1001_0010;  // stream 1,0,0,1,0,0,1,0 (MSB first)
  logic [7:0] exp_ovl = 8'b0000_1001; // flags after bits 5 and 8
  logic [7:0] exp_nov = 8'b0000_1000; // flag after bit 5 only

  initial begin
    #12;
    chk("rst_flag", flag, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_armed", armed, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Overlapping 10010
    load(8'h12, 5, 1'b1, 1'b0, 1'b0);
    chk("ld_armed", armed, 1);
    chk("ld_err", cfg_err, 0);
    for (int i = 7; i >= 0; i--) bit_in(s10010[i], exp_ovl[i], "ovl_flag");
    chk("ovl_cnt", match_cnt, 2);

    // Non-overlapping: load clears count
    load(8'h12, 5, 1'b0, 1'b0, 1'b0);
    chk("nov_clr_cnt", match_cnt, 0);
    for (int i = 7; i >= 0; i--) bit_in(s10010[i], exp_nov[i], "nov_flag");
    chk("nov_cnt", match_cnt, 1);

    // Gaps between valid bits
    load(8'h12, 5, 1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 3; i--) begin
      bit_in(s10010[i], (i == 3), "gap_bit_flag");
      gap();
      gap();
    end
    chk("gap_cnt", match_cnt, 1);

    // Invalid length 0
    load(8'h12, 0, 1'b1, 1'b0, 1'b0);
    chk("inv0_err", cfg_err, 1);
    chk("inv0_armed", armed, 0);
    chk("inv0_cnt", match_cnt, 0);
    for (int i = 7; i >= 0; i--) bit_in(s10010[i], 1'b0, "inv0_flag");
    chk("inv0_err_pulse", cfg_err, 0);

    // Invalid length 9 after a valid load
    load(8'h12, 5, 1'b1, 1'b0, 1'b0);
    chk("rearm", armed, 1);
    load(8'h12, 9, 1'b1, 1'b0, 1'b0);
    chk("inv9_err", cfg_err, 1);
    chk("inv9_armed", armed, 0);
    for (int i = 7; i >= 0; i--) bit_in(s10010[i], 1'b0, "inv9_flag");
    chk("inv9_cnt", match_cnt, 0);

    // Length-1 pattern flags every bit; CNT_W=2 instance saturates at 3
    load(8'h01, 1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) bit_in(1'b1, 1'b1, "sat_flag");
    chk("sat_cnt2", match_cnt2, 3);
    chk("sat_cnt8", match_cnt, 6);
    chk("sat_armed2", armed2, 1);

    // Bit coincident with load is discarded
    load(8'h03, 2, 1'b1, 1'b1, 1'b1);
    chk("pri_flag0", flag, 0);
    bit_in(1'b1, 1'b0, "pri_flag1");
    bit_in(1'b1, 1'b1, "pri_flag2");
    chk("pri_cnt", match_cnt, 1);

    // Async reset mid-stream
    load(8'h12, 5, 1'b1, 1'b0, 1'b0);
    bit_in(1'b1, 1'b0, "rs_b1");
    bit_in(1'b0, 1'b0, "rs_b2");
    bit_in(1'b0, 1'b0, "rs_b3");
    #2 rst_n = 1'b0;
    #1;
    chk("rs_armed", armed, 0);
    chk("rs_cnt", match_cnt, 0);
    chk("rs_flag", flag, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 7; i >= 0; i--) bit_in(s10010[i], 1'b0, "rs_noflag");
    chk("rs_armed_after", armed, 0);
    chk("rs_cnt_after", match_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
